adder_sequencer: RTL and testbench

Clocked front/back-end for the 16-bit latch-based carry-select adder (`modifiedcarrylatch`). It accepts operand pairs over a valid/ready handshake and drives the adder's operand and `enable` pins through a latch-load phase and an evaluate phase. It then captures `sum`/`cout` into registers and presents the result over a second valid/ready handshake. It is the only synchronous boundary around the adder: upstream logic never drives the adder directly.

---
 rtl/adder_sequencer_if.sv | 28 ++
 rtl/adder_sequencer.sv | 128 ++++++++++++
 tb/tb_adder_sequencer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/adder_sequencer_if.sv
// Bundles the operand/result handshakes, the adder pin bus and the op counter
// of adder_sequencer. slave is the sequencer's view, master the environment's.
interface adder_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic        add_enable;
  logic [15:0] add_sum;
  logic        add_cout;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_cout;
  logic [15:0] op_count;

  modport slave (
    input  in_valid, in_a, in_b, add_sum, add_cout, out_ready,
    output in_ready, add_a, add_b, add_enable, out_valid, out_sum, out_cout, op_count
  );

  modport master (
    output in_valid, in_a, in_b, add_sum, add_cout, out_ready,
    input  in_ready, add_a, add_b, add_enable, out_valid, out_sum, out_cout, op_count
  );
endinterface

// File: rtl/adder_sequencer.sv
// Synchronous wrapper around the latch-based carry-select adder: load, evaluate, capture, hand off.
// Optional ADDSEQ_SAT_EN saturates out_sum to 16'hFFFF on carry-out.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand pair
// LOAD  | add_enable high, carry-1 latches capturing (LOAD_CYCLES)
// EVAL  | add_enable low, adder settling (SETTLE_CYCLES), capture at end
// DONE  | out_valid high, result held until out_ready
module adder_sequencer #(
  parameter int LOAD_CYCLES   = 1,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  adder_sequencer_if.slave   bus
);

  localparam int MAX_CYCLES = (LOAD_CYCLES > SETTLE_CYCLES) ? LOAD_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD_INIT   = CNT_W'(LOAD_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EVAL = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      a_q, a_d;
  logic [15:0]      b_q, b_d;
  logic             en_q, en_d;
  logic [15:0]      sum_q, sum_d;
  logic             cout_q, cout_d;
  logic [15:0]      ops_q, ops_d;
  logic             cnt_tc;
  logic [15:0]      sum_capture;

  assign cnt_tc = (cnt_q == CNT_ONE);

`ifdef ADDSEQ_SAT_EN
  assign sum_capture = bus.add_cout ? 16'hFFFF : bus.add_sum;
`else
  assign sum_capture = bus.add_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      en_q    <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      en_q    <= en_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ops_q   <= ops_d;
    end
  end

  // add_enable is computed as a next-state value so the adder pin comes straight off a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    en_d    = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ops_d   = ops_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          cnt_d   = LOAD_INIT;
          en_d    = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (cnt_tc) begin
          cnt_d   = SETTLE_INIT;
          state_d = S_EVAL;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          en_d  = 1'b1;
        end
      end
      S_EVAL: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_tc) begin
          sum_d   = sum_capture;
          cout_d  = bus.add_cout;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          ops_d   = ops_q + 16'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready   = (state_q == S_IDLE);
  assign bus.out_valid  = (state_q == S_DONE);
  assign bus.add_a      = a_q;
  assign bus.add_b      = b_q;
  assign bus.add_enable = en_q;
  assign bus.out_sum    = sum_q;
  assign bus.out_cout   = cout_q;
  assign bus.op_count   = ops_q;

endmodule

// File: tb/tb_adder_sequencer.sv
// Scoreboard bench for adder_sequencer with a behavioural latch-adder stand-in.
`timescale 1ns/1ps
module tb_adder_sequencer;
  localparam int L = 1;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adder_sequencer_if bus();

  adder_sequencer #(.LOAD_CYCLES(L), .SETTLE_CYCLES(S)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // Adder stand-in: only gives a true sum once the current operands were latched under enable
  // and enable has dropped; otherwise it shows a poison value.
  logic [31:0] lat_q = 32'hFFFF_FFFF;
  always @(posedge clk) if (bus.add_enable) lat_q <= {bus.add_a, bus.add_b};
  assign {bus.add_cout, bus.add_sum} = (!bus.add_enable && lat_q == {bus.add_a, bus.add_b}) ?
                                       ({1'b0, bus.add_a} + {1'b0, bus.add_b}) : 17'h1_A5A5;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [16:0] ref_add(input int unsigned a, input int unsigned b);
    int unsigned s;
    logic [16:0] r;
    s = a + b;
    r = 17'(s);
`ifdef ADDSEQ_SAT_EN
    if (s > 32'd65535) r = {1'b1, 16'hFFFF};
`endif
    return r;
  endfunction

  logic [16:0] exp_q[$];
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor
  int          acc_cyc, en_cnt, op_model;
  bit          busy, prev_valid;
  logic [16:0] prev_out;
  logic [15:0] pend_a, pend_b;
  logic [16:0] got;
  always @(negedge clk) begin
    if (!rst_n) begin
      busy = 0; prev_valid = 0; en_cnt = 0; op_model = 0;
    end else begin
      if (bus.add_enable) en_cnt++;
      got = {bus.out_cout, bus.out_sum};
      if (busy && !bus.out_valid) begin
        chk("hold_add_a", bus.add_a, pend_a);
        chk("hold_add_b", bus.add_b, pend_b);
      end
      if (bus.in_valid && bus.in_ready) begin
        busy = 1; pend_a = bus.in_a; pend_b = bus.in_b;
        acc_cyc = cyc + 1; en_cnt = 0;
      end
      if (bus.out_valid && !prev_valid) begin
        chk("latency", cyc - acc_cyc, L + S);
        chk("enable_cycles", en_cnt, L);
        busy = 0;
      end
      if (bus.out_valid && prev_valid) begin
        chk("done_stable", got, prev_out);
        chk("in_ready_in_done", bus.in_ready, 0);
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("scoreboard_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("result", got, exp_q.pop_front());
        chk("op_count", bus.op_count, op_model[15:0]);
        op_model = (op_model + 1) & 16'hFFFF;
      end
      prev_valid = bus.out_valid;
      prev_out   = got;
    end
  end

  // out_ready driver: 0 = held high, 1 = random, 2 = held low
  int rdy_mode = 0;
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  int n_sent = 0;
  int last_acc;

  task automatic send(input logic [15:0] a, input logic [15:0] b, input bit hold);
    bit ok;
    ok = 0;
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(ref_add(a, b));
        ok = 1;
        break;
      end
    end
    chk("accept_in_time", 32'(ok), 32'd1);
    @(posedge clk); #1;
    last_acc = cyc;
    n_sent++;
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((exp_q.size() > 0 || bus.out_valid) && i < 200) begin
      @(posedge clk); #1;
      i++;
    end
    chk("drain_in_time", 32'(i < 200), 32'd1);
  endtask

  logic [15:0] va[4] = '{16'h0003, 16'h07FF, 16'h8000, 16'hFFFF};
  logic [15:0] vb[4] = '{16'h0005, 16'h0001, 16'h8000, 16'h0001};

  initial begin
    int prev_acc, t;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
    #12;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_add_enable", bus.add_enable, 0);
    chk("rst_add_ab", {bus.add_a, bus.add_b}, 0);
    chk("rst_out", {bus.out_cout, bus.out_sum}, 0);
    chk("rst_op_count", bus.op_count, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // reset in the middle of EVAL discards the operation
    send(16'h1234, 16'h1111, 0);
    @(posedge clk); #1;
    chk("in_eval_enable_low", bus.add_enable, 0);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    n_sent = 0;
    chk("mid_rst_in_ready", bus.in_ready, 1);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_add_enable", bus.add_enable, 0);
    chk("mid_rst_add_ab", {bus.add_a, bus.add_b}, 0);
    chk("mid_rst_out", {bus.out_cout, bus.out_sum}, 0);
    chk("mid_rst_op_count", bus.op_count, 0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // directed vectors
    for (int i = 0; i < 4; i++) begin
      send(va[i], vb[i], 0);
      drain();
      chk("directed_op_count", bus.op_count, 32'(n_sent));
    end

    // backpressure in DONE with an ignored in_valid pulse
    rdy_mode = 2;
    send(16'h00F0, 16'h000F, 0);
    t = 0;
    while (!bus.out_valid && t < 50) begin @(posedge clk); #1; t++; end
    chk("bp_reached_done", bus.out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin bus.in_valid = 1'b1; bus.in_a = 16'hBEEF; bus.in_b = 16'hCAFE; end
      if (i == 4) bus.in_valid = 1'b0;
      @(posedge clk); #1;
      chk("bp_in_ready_low", bus.in_ready, 0);
      chk("bp_out_valid_high", bus.out_valid, 1);
    end
    chk("bp_operand_kept", bus.add_a, 16'h00F0);
    rdy_mode = 0;
    drain();

    // randomized traffic with random backpressure
    rdy_mode = 1;
    for (int i = 0; i < 200; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      repeat (gap) @(posedge clk);
      #1;
      send(16'($urandom), 16'($urandom), 0);
    end
    rdy_mode = 0;
    drain();

    // back-to-back throughput
    prev_acc = 0;
    for (int i = 0; i < 40; i++) begin
      send(16'($urandom), 16'($urandom), 1);
      if (i > 0) chk("accept_period", last_acc - prev_acc, L + S + 2);
      prev_acc = last_acc;
    end
    bus.in_valid = 1'b0;
    drain();

    chk("final_op_count", bus.op_count, 32'(n_sent & 16'hFFFF));
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
